// File: rtl/vec_det_pkg.sv
// Shared definitions for the vector bit enumerator and its leading-one detector.
// Contents: vector/position widths, empty-position code, FSM state encoding,
// and a helper mapping an MSB-first position back to a bit index.
package vec_det_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned POS_W  = 6;
    localparam int unsigned BIT_W  = 5;

    // Position reported when no bit is set.
    localparam logic [POS_W-1:0] POS_EMPTY = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ZERO = 2'd2
    } state_e;

    // MSB-first position (0 = bit 31) back to the bit index it names.
    function automatic logic [BIT_W-1:0] pos_to_bit(input logic [POS_W-1:0] pos);
        return 5'd31 - pos[BIT_W-1:0];
    endfunction

endpackage

// File: rtl/lead_one_det.sv
// Combinational 32-bit leading-one detector built as a binary priority tree.
// Ports:
//   vec_i  in   DATA_W  vector to search
//   pos_o  out  POS_W   MSB-first position of the highest set bit (bit31 -> 0),
//                       POS_EMPTY (32) when vec_i is zero
module lead_one_det
    import vec_det_pkg::*;
(
    input  logic [DATA_W-1:0] vec_i,
    output logic [POS_W-1:0]  pos_o
);

    // Leaves re-ordered so that leaf index equals MSB-first position.
    logic [31:0]       v0;
    logic [15:0]       v1;
    logic [15:0][0:0]  p1;
    logic [7:0]        v2;
    logic [7:0][1:0]   p2;
    logic [3:0]        v3;
    logic [3:0][2:0]   p3;
    logic [1:0]        v4;
    logic [1:0][3:0]   p4;
    logic              v5;
    logic [4:0]        p5;

    genvar g;

    for (g = 0; g < 32; g++) begin : g_leaf
        assign v0[g] = vec_i[DATA_W-1-g];
    end

    // Each node prefers its left (lower-position) child; the child select
    // becomes the next more-significant bit of the position.
    for (g = 0; g < 16; g++) begin : g_l1
        assign v1[g] = v0[2*g] | v0[2*g+1];
        assign p1[g] = ~v0[2*g];
    end

    for (g = 0; g < 8; g++) begin : g_l2
        assign v2[g] = v1[2*g] | v1[2*g+1];
        assign p2[g] = v1[2*g] ? {1'b0, p1[2*g]} : {1'b1, p1[2*g+1]};
    end

    for (g = 0; g < 4; g++) begin : g_l3
        assign v3[g] = v2[2*g] | v2[2*g+1];
        assign p3[g] = v2[2*g] ? {1'b0, p2[2*g]} : {1'b1, p2[2*g+1]};
    end

    for (g = 0; g < 2; g++) begin : g_l4
        assign v4[g] = v3[2*g] | v3[2*g+1];
        assign p4[g] = v3[2*g] ? {1'b0, p3[2*g]} : {1'b1, p3[2*g+1]};
    end

    assign v5    = v4[0] | v4[1];
    assign p5    = v4[0] ? {1'b0, p4[0]} : {1'b1, p4[1]};
    assign pos_o = v5 ? {1'b0, p5} : POS_EMPTY;

endmodule

// File: rtl/vector_bit_enumerator.sv
// Accepts a 32-bit vector and emits the MSB-first position of each set bit,
// one per beat, clearing each bit as it goes. A zero vector gives one beat
// with position 32. A new vector may load on the last-beat handshake.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  input handshake for data_in
//   data_in         vector to enumerate
//   out_valid/ready output handshake
//   pos_out         current position (32 for an empty vector)
//   out_idx         beat index within the current vector
//   out_last        current beat is the final one for this vector
module vector_bit_enumerator
    import vec_det_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  pos_out,
    output logic [POS_W-1:0]  out_idx,
    output logic              out_last
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   vec_q, vec_d;
    logic [POS_W-1:0]    idx_q, idx_d;
    logic [POS_W-1:0]    lod_pos;
    logic [DATA_W-1:0]   vec_clr;
    logic                in_fire;

    lead_one_det u_lod (
        .vec_i (vec_q),
        .pos_o (lod_pos)
    );

    assign out_idx = idx_q;

    // Next-state, handshake and beat outputs.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        pos_out   = POS_EMPTY;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        in_fire   = 1'b0;

        // Vector with the current leading one removed.
        vec_clr = vec_q & ~(DATA_W'(1) << pos_to_bit(lod_pos));

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SCAN: begin
                out_valid = 1'b1;
                pos_out   = lod_pos;
                out_last  = (vec_clr == '0);
                if (out_ready) begin
                    vec_d = vec_clr;
                    if (out_last) begin
                        // Index returns to 0 so it never reads 32 in IDLE.
                        idx_d    = '0;
                        state_d  = IDLE;
                        in_ready = 1'b1;
                    end else begin
                        idx_d = idx_q + POS_W'(1);
                    end
                end
            end
            ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d  = IDLE;
                    in_ready = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load overrides the return to IDLE, giving back-to-back vectors.
        in_fire = in_valid & in_ready;
        if (in_fire) begin
            vec_d   = data_in;
            idx_d   = '0;
            state_d = (data_in != '0) ? SCAN : ZERO;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_vector_bit_enumerator.sv
// Directed bench for vector_bit_enumerator: table of vectors with hand-computed
// beat counts and first/last positions, plus hand-written handshake sequences.
module tb_vector_bit_enumerator;
    import vec_det_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [POS_W-1:0]  pos_out;
    logic [POS_W-1:0]  out_idx;
    logic              out_last;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    vector_bit_enumerator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pos_out   (pos_out),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct {
        logic [31:0] data;
        int unsigned beats;
        logic [5:0]  first_pos;
        logic [5:0]  last_pos;
    } vec_rec_t;

    vec_rec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: scan from bit 31 downward for the first set bit.
    function automatic logic [5:0] model_pos(input logic [31:0] m);
        for (int b = 31; b >= 0; b--) begin
            if (m[b]) return 6'(31 - b);
        end
        return 6'd32;
    endfunction

    // Load one vector from IDLE with out_ready=1 and walk every beat.
    task automatic run_vec(input vec_rec_t r);
        logic [31:0] m;
        int unsigned beat;
        logic [5:0]  ep;
        logic        el;
        bit          done;
        in_valid  = 1'b1;
        data_in   = r.data;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = 32'hDEAD_BEEF;
        m    = r.data;
        beat = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            ep = model_pos(m);
            el = ($countones(m) <= 1);
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_pos", 32'(pos_out), 32'(ep));
            chk("beat_idx", 32'(out_idx), beat);
            chk("beat_last", 32'(out_last), 32'(el));
            chk("beat_in_ready", 32'(in_ready), 32'(el));
            if (beat == 0) chk("first_pos", 32'(pos_out), 32'(r.first_pos));
            if (out_last) begin
                chk("last_pos", 32'(pos_out), 32'(r.last_pos));
                chk("beat_count", beat + 1, r.beats);
                done = 1'b1;
            end
            if (m != 0) m[5'd31 - ep[4:0]] = 1'b0;
            beat++;
            @(posedge clk); #1;
        end
        if (!done) chk("beat_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("after_out_valid", 32'(out_valid), 32'd0);
        chk("after_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] exp4[3];
        int unsigned k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pos", 32'(pos_out), 32'd32);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        @(posedge clk); #1;

        tbl[0] = '{32'h8000_0001, 2,  6'd0,  6'd31};
        tbl[1] = '{32'h0000_0000, 1,  6'd32, 6'd32};
        tbl[2] = '{32'hFFFF_FFFF, 32, 6'd0,  6'd31};
        tbl[3] = '{32'h0000_0001, 1,  6'd31, 6'd31};
        tbl[4] = '{32'h8000_0000, 1,  6'd0,  6'd0};
        tbl[5] = '{32'hA5A5_0000, 8,  6'd0,  6'd15};
        tbl[6] = '{32'h0001_0000, 1,  6'd15, 6'd15};
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Backpressure: out_ready alternates; in_valid high only while stalled.
        exp4[0] = 6'd11;
        exp4[1] = 6'd14;
        exp4[2] = 6'd21;
        in_valid  = 1'b1;
        data_in   = 32'h0012_0400;
        out_ready = 1'b0;
        @(posedge clk); #1;
        k = 0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            out_ready = (c % 2) == 1;
            in_valid  = !out_ready;
            data_in   = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pos", 32'(pos_out), 32'(exp4[k]));
            chk("bp_idx", 32'(out_idx), k);
            chk("bp_last", 32'(out_last), 32'(k == 2));
            chk("bp_in_ready", 32'(in_ready), 32'(out_ready && k == 2));
            if (out_ready) k++;
            @(posedge clk); #1;
        end
        if (k != 3) chk("bp_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Zero vector held under backpressure.
        in_valid  = 1'b1;
        data_in   = 32'h0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("zero_valid", 32'(out_valid), 32'd1);
            chk("zero_pos", 32'(pos_out), 32'd32);
            chk("zero_last", 32'(out_last), 32'd1);
            chk("zero_idx", 32'(out_idx), 32'd0);
            chk("zero_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("zero_rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Back-to-back vectors with in_valid held high.
        in_valid  = 1'b1;
        data_in   = 32'h4000_0000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        data_in = 32'h0000_0002;
        @(negedge clk);
        chk("b2b_a_pos", 32'(pos_out), 32'd1);
        chk("b2b_a_last", 32'(out_last), 32'd1);
        chk("b2b_a_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_b_valid", 32'(out_valid), 32'd1);
        chk("b2b_b_pos", 32'(pos_out), 32'd30);
        chk("b2b_b_last", 32'(out_last), 32'd1);
        chk("b2b_b_idx", 32'(out_idx), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a vector discards the remaining bits.
        in_valid  = 1'b1;
        data_in   = 32'hF000_0000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rmid_pos0", 32'(pos_out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid_pos1", 32'(pos_out), 32'd1);
        chk("rmid_idx1", 32'(out_idx), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_valid", 32'(out_valid), 32'd0);
        chk("rmid_in_ready", 32'(in_ready), 32'd1);
        chk("rmid_idx", 32'(out_idx), 32'd0);
        chk("rmid_pos", 32'(pos_out), 32'd32);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rmid_quiet", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
